role_udp_echo_sf: RTL and testbench
===================================

Name: role_udp_echo_sf

Overview:
- Parametrised store-and-forward UDP echo for the Themisto ROLE; sits between the NRC UDP data/meta streams and the role's application logic.
- Buffers each inbound datagram whole, counts its bytes, swaps the source/destination fields of its 80-bit meta, then returns meta followed by data to NRC.
- Adds oversize-datagram rollback/drop, a sink mode and MMIO-visible counters.

Parameters:
- DATA_W, 64: data stream width in bits; multiple of 8; tkeep width is DATA_W/8.
- DEPTH, 512: data FIFO depth in words; power of two; must be >= 2*MAX_DGM_WORDS.
- MAX_DGM_WORDS, 256: maximum datagram length in words; MAX_DGM_WORDS*DATA_W/8 <= 65535.
- META_DEPTH, 16: committed-meta FIFO depth; power of two.
- RX_PORT_MASK, 32'h0000_0001: value driven on the open-port vector.

Ports:
- piSHL_156_25Clk in 1: sole clock.
- piSHL_156_25Rst in 1: synchronous, active-high reset.
- piSHL_Mmio_UdpEchoCtrl in 2: mode. 00 = echo with swap; 01 = echo with meta unchanged except len; 1x = sink.
- siNRC_Udp_Data_tdata/tkeep/tvalid/tlast/tready, in/in/in/in/out, DATA_W/DATA_W/8/1/1/1: inbound data.
- siNRC_Role_Udp_Meta_TDATA/TVALID/TREADY/TKEEP/TLAST, in/in/out/in/in, 80/1/1/10/1: inbound meta. TKEEP and TLAST are ignored.
- soNRC_Udp_Data_tdata/tkeep/tvalid/tlast/tready, out/out/out/out/in: outbound data.
- soROLE_Nrc_Udp_Meta_TDATA/TVALID/TREADY/TKEEP/TLAST, out/out/in/out/out, 80/1/1/10/1: outbound meta.
- poROL_Nrc_Udp_Rx_ports out 32: constant RX_PORT_MASK.
- poDgmCnt out 16: datagrams committed; wraps at 16 bits.
- poDropCnt out 16: datagrams dropped (oversize or sink); wraps at 16 bits.

Behaviour:
- Meta layout:
  - [7:0] dst_rank, [15:8] src_rank, [31:16] dst_port, [47:32] src_port, [63:48] len (bytes), [79:64] reserved.
- Outbound meta fields:
  - Mode 00: dst_rank<=src_rank, src_rank<=dst_rank, dst_port<=src_port, src_port<=dst_port.
  - Mode 01: all fields pass unchanged.
  - Both modes: len is replaced by the counted byte total; reserved bits are driven 0.
  - TKEEP is always 10'h3FF; TLAST is always 1.
- Reset values: every tready, tvalid and TVALID is 0; counters are 0; FIFOs are empty; both FSMs are in IDLE. Reset applied mid-datagram discards all partial and buffered datagrams; valids drop on the cycle after reset is sampled.
- RX FSM, IDLE:
  - Meta TREADY is asserted only when meta FIFO is not full AND data FIFO free space >= MAX_DGM_WORDS.
  - On the meta handshake: capture the meta, sample the mode, record start pointer wr_start = wr_ptr, clear the byte and word counters, go to DATA (mode 1x goes to DROP).
  - Data tready is 0 in IDLE; the data stream is not accepted before its meta.
- RX FSM, DATA:
  - Data tready = 1. Each beat is written to the FIFO as {tlast, tkeep, tdata}.
  - Byte count += popcount(tkeep). tkeep must be all-ones except on the last beat, where it is LSB-contiguous.
  - On a tlast beat with word count <= MAX_DGM_WORDS: go to COMMIT.
  - On the beat that would be word MAX_DGM_WORDS+1 without tlast, the beat is not written; wr_ptr rewinds to wr_start and the FSM goes to DROP. If that same beat carries tlast, wr_ptr rewinds, poDropCnt++ and the FSM returns to IDLE.
- RX FSM, DROP:
  - Data tready = 1; beats are discarded.
  - On tlast: poDropCnt++ and return to IDLE.
  - Sink mode increments poDropCnt once per datagram.
- RX FSM, COMMIT (1 cycle):
  - Push the built meta into the meta FIFO; data words become visible to TX (committed pointer = wr_ptr); poDgmCnt++; go to IDLE.
- TX FSM:
  - IDLE -> META when the meta FIFO is not empty.
  - META: assert TVALID; on TREADY, pop the entry and go to DATA.
  - DATA: stream words from the committed region with valid/ready; on the tlast handshake return to IDLE.
- Handshake rules:
  - Output tvalid may be 1 only in DATA. Once tvalid is asserted, tdata/tkeep/tlast hold stable until tready.
  - Meta output never precedes commit of its datagram's data.
- Latency: the first meta out appears 2 cycles after the COMMIT cycle with the downstream ready. Data can flow back-to-back at 1 word/cycle.
- Concurrency: RX writes and TX reads of the data FIFO may occur in the same cycle. Free space is computed against the TX read pointer; pointers are log2(DEPTH)+1 bits with wrap bit.

Test Plan:
1. Mode 00, meta {dst_rank=1, src_rank=3, dst_port=0x0A9E, src_port=0x1234}, 3 words, last tkeep=8'h0F → out meta dst_rank=3, src_rank=1, dst_port=0x1234, src_port=0x0A9E, len=20; 3 identical words; poDgmCnt=1.
2. Mode 01, same stimulus → meta fields unchanged, len=20.
3. MAX_DGM_WORDS=4, a 6-word datagram followed by a 2-word datagram (full tkeep) → first is dropped, poDropCnt=1, FIFO pointers restored; second echoes with len=16.
4. Downstream ready toggling 1/0 each cycle while 5 datagrams arrive back-to-back → all echoed in order, no data corruption, tvalid never deasserts without a handshake.
5. Mode 10, 3 datagrams → no output valid, poDropCnt=3, input never stalls beyond the meta handshake.
6. Reset asserted mid-DATA with 2 committed datagrams → next cycle all valids are 0, counters are 0; a fresh datagram after reset echoes correctly.

Source files
------------

// File: rtl/role_udp_echo_sf.sv
// Store-and-forward UDP echo: buffers each inbound datagram whole, counts its bytes,
// rebuilds the meta (optionally swapping source/destination) and replays meta then data.
module role_udp_echo_sf #(
    parameter int          DATA_W        = 64,
    parameter int          DEPTH         = 512,
    parameter int          MAX_DGM_WORDS = 256,
    parameter int          META_DEPTH    = 16,
    parameter logic [31:0] RX_PORT_MASK  = 32'h0000_0001
) (
    input  logic                piSHL_156_25Clk,
    input  logic                piSHL_156_25Rst,
    input  logic [1:0]          piSHL_Mmio_UdpEchoCtrl,
    input  logic [DATA_W-1:0]   siNRC_Udp_Data_tdata,
    input  logic [DATA_W/8-1:0] siNRC_Udp_Data_tkeep,
    input  logic                siNRC_Udp_Data_tvalid,
    input  logic                siNRC_Udp_Data_tlast,
    output logic                siNRC_Udp_Data_tready,
    input  logic [79:0]         siNRC_Role_Udp_Meta_TDATA,
    input  logic                siNRC_Role_Udp_Meta_TVALID,
    output logic                siNRC_Role_Udp_Meta_TREADY,
    input  logic [9:0]          siNRC_Role_Udp_Meta_TKEEP,
    input  logic                siNRC_Role_Udp_Meta_TLAST,
    output logic [DATA_W-1:0]   soNRC_Udp_Data_tdata,
    output logic [DATA_W/8-1:0] soNRC_Udp_Data_tkeep,
    output logic                soNRC_Udp_Data_tvalid,
    output logic                soNRC_Udp_Data_tlast,
    input  logic                soNRC_Udp_Data_tready,
    output logic [79:0]         soROLE_Nrc_Udp_Meta_TDATA,
    output logic                soROLE_Nrc_Udp_Meta_TVALID,
    input  logic                soROLE_Nrc_Udp_Meta_TREADY,
    output logic [9:0]          soROLE_Nrc_Udp_Meta_TKEEP,
    output logic                soROLE_Nrc_Udp_Meta_TLAST,
    output logic [31:0]         poROL_Nrc_Udp_Rx_ports,
    output logic [15:0]         poDgmCnt,
    output logic [15:0]         poDropCnt
);
    localparam int KW  = DATA_W / 8;
    localparam int WW  = DATA_W + KW + 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int MA  = $clog2(META_DEPTH);
    localparam int MPW = MA + 1;
    localparam logic [PW-1:0]  USED_LIMIT = PW'(DEPTH - MAX_DGM_WORDS);
    localparam logic [MPW-1:0] META_FULL  = MPW'(META_DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_DROP, RX_COMMIT} rxState_t;
    typedef enum logic [1:0] {TX_IDLE, TX_META, TX_DATA} txState_t;

    rxState_t rxState, rxNext;
    txState_t txState, txNext;

    logic [WW-1:0]  dataMem [DEPTH];
    logic [79:0]    metaMem [META_DEPTH];
    logic [PW-1:0]  wrPtr, wrStart, commitPtr, rdPtr, usedWords;
    logic [MPW-1:0] mWr, mRd;
    logic [47:0]    metaReg;
    logic           passMode, running;
    logic [15:0]    byteCnt, wordCnt, dgmCnt, dropCnt;
    logic [79:0]    builtMeta;
    logic [WW-1:0]  rdWord;
    logic           metaFull, metaEmpty, freeOk, metaAccept;
    logic           beatWrite, rewind, dropInc, metaPop, dataPop;
    logic           unusedMetaBits;

    function automatic logic [15:0] keepBytes(input logic [KW-1:0] keep);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < KW; i++) n = n + {15'd0, keep[i]};
        return n;
    endfunction

    assign usedWords  = wrPtr - rdPtr;
    assign freeOk     = usedWords <= USED_LIMIT;
    assign metaFull   = (mWr - mRd) == META_FULL;
    assign metaEmpty  = mWr == mRd;
    assign metaAccept = siNRC_Role_Udp_Meta_TREADY && siNRC_Role_Udp_Meta_TVALID;
    assign unusedMetaBits = ^{siNRC_Role_Udp_Meta_TKEEP, siNRC_Role_Udp_Meta_TLAST,
                              siNRC_Role_Udp_Meta_TDATA[79:48]};

    // Length is always the counted total; reserved bits go out as zero.
    always_comb begin
        builtMeta = {16'h0000, byteCnt, metaReg};
        if (!passMode)
            builtMeta[47:0] = {metaReg[31:16], metaReg[47:32], metaReg[7:0], metaReg[15:8]};
    end

    always_comb begin
        rxNext                     = rxState;
        siNRC_Udp_Data_tready      = 1'b0;
        siNRC_Role_Udp_Meta_TREADY = 1'b0;
        beatWrite                  = 1'b0;
        rewind                     = 1'b0;
        dropInc                    = 1'b0;
        unique case (rxState)
            RX_IDLE: begin
                siNRC_Role_Udp_Meta_TREADY = running && !metaFull && freeOk;
                if (metaAccept)
                    rxNext = piSHL_Mmio_UdpEchoCtrl[1] ? RX_DROP : RX_DATA;
            end
            RX_DATA: begin
                siNRC_Udp_Data_tready = 1'b1;
                if (siNRC_Udp_Data_tvalid) begin
                    // A beat past the word limit abandons everything written for this datagram.
                    if (wordCnt == 16'(MAX_DGM_WORDS)) begin
                        rewind = 1'b1;
                        if (siNRC_Udp_Data_tlast) begin
                            dropInc = 1'b1;
                            rxNext  = RX_IDLE;
                        end else begin
                            rxNext = RX_DROP;
                        end
                    end else begin
                        beatWrite = 1'b1;
                        if (siNRC_Udp_Data_tlast) rxNext = RX_COMMIT;
                    end
                end
            end
            RX_DROP: begin
                siNRC_Udp_Data_tready = 1'b1;
                if (siNRC_Udp_Data_tvalid && siNRC_Udp_Data_tlast) begin
                    dropInc = 1'b1;
                    rxNext  = RX_IDLE;
                end
            end
            RX_COMMIT: rxNext = RX_IDLE;
            default:   rxNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge piSHL_156_25Clk) begin
        if (piSHL_156_25Rst) begin
            rxState   <= RX_IDLE;
            running   <= 1'b0;
            wrPtr     <= '0;
            wrStart   <= '0;
            commitPtr <= '0;
            mWr       <= '0;
            metaReg   <= '0;
            passMode  <= 1'b0;
            byteCnt   <= '0;
            wordCnt   <= '0;
            dgmCnt    <= '0;
            dropCnt   <= '0;
        end else begin
            rxState <= rxNext;
            running <= 1'b1;
            if (metaAccept) begin
                metaReg  <= siNRC_Role_Udp_Meta_TDATA[47:0];
                passMode <= piSHL_Mmio_UdpEchoCtrl[0];
                wrStart  <= wrPtr;
                byteCnt  <= '0;
                wordCnt  <= '0;
            end
            if (beatWrite) begin
                wrPtr   <= wrPtr + PW'(1);
                byteCnt <= byteCnt + keepBytes(siNRC_Udp_Data_tkeep);
                wordCnt <= wordCnt + 16'd1;
            end
            if (rewind) wrPtr <= wrStart;
            if (dropInc) dropCnt <= dropCnt + 16'd1;
            if (rxState == RX_COMMIT) begin
                mWr       <= mWr + MPW'(1);
                commitPtr <= wrPtr;
                dgmCnt    <= dgmCnt + 16'd1;
            end
        end
    end

    always_ff @(posedge piSHL_156_25Clk) begin
        if (beatWrite)
            dataMem[wrPtr[AW-1:0]] <= {siNRC_Udp_Data_tlast, siNRC_Udp_Data_tkeep, siNRC_Udp_Data_tdata};
        if (rxState == RX_COMMIT)
            metaMem[mWr[MA-1:0]] <= builtMeta;
    end

    // TX only ever reads below commitPtr, so a presented word cannot change under it.
    assign rdWord = dataMem[rdPtr[AW-1:0]];

    always_comb begin
        txNext                     = txState;
        soROLE_Nrc_Udp_Meta_TVALID = 1'b0;
        soNRC_Udp_Data_tvalid      = 1'b0;
        metaPop                    = 1'b0;
        dataPop                    = 1'b0;
        unique case (txState)
            TX_IDLE: if (!metaEmpty) txNext = TX_META;
            TX_META: begin
                soROLE_Nrc_Udp_Meta_TVALID = 1'b1;
                if (soROLE_Nrc_Udp_Meta_TREADY) begin
                    metaPop = 1'b1;
                    txNext  = TX_DATA;
                end
            end
            TX_DATA: begin
                soNRC_Udp_Data_tvalid = rdPtr != commitPtr;
                if (soNRC_Udp_Data_tvalid && soNRC_Udp_Data_tready) begin
                    dataPop = 1'b1;
                    if (rdWord[WW-1]) txNext = TX_IDLE;
                end
            end
            default: txNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge piSHL_156_25Clk) begin
        if (piSHL_156_25Rst) begin
            txState <= TX_IDLE;
            rdPtr   <= '0;
            mRd     <= '0;
        end else begin
            txState <= txNext;
            if (dataPop) rdPtr <= rdPtr + PW'(1);
            if (metaPop) mRd <= mRd + MPW'(1);
        end
    end

    assign soNRC_Udp_Data_tdata      = rdWord[DATA_W-1:0];
    assign soNRC_Udp_Data_tkeep      = rdWord[DATA_W +: KW];
    assign soNRC_Udp_Data_tlast      = rdWord[WW-1];
    assign soROLE_Nrc_Udp_Meta_TDATA = metaMem[mRd[MA-1:0]];
    assign soROLE_Nrc_Udp_Meta_TKEEP = 10'h3FF;
    assign soROLE_Nrc_Udp_Meta_TLAST = 1'b1;
    assign poROL_Nrc_Udp_Rx_ports    = RX_PORT_MASK;
    assign poDgmCnt                  = dgmCnt;
    assign poDropCnt                 = dropCnt;
endmodule

// File: tb/tb_role_udp_echo_sf.sv
// Bench for role_udp_echo_sf: datagram-level reference model with queues of expected meta
// and words, a per-cycle output checker, directed scenarios and a randomized phase.
module tb_role_udp_echo_sf;
    localparam int DATA_W     = 64;
    localparam int KW         = DATA_W / 8;
    localparam int DEPTH      = 16;
    localparam int MAXW       = 4;
    localparam int META_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic [DATA_W-1:0] inData = '0;
    logic [KW-1:0]     inKeep = '0;
    logic              inValid = 1'b0, inLast = 1'b0, inReady;
    logic [79:0]       inMeta = '0;
    logic              inMetaValid = 1'b0, inMetaReady, inMetaLast = 1'b0;
    logic [9:0]        inMetaKeep = '0;
    logic [DATA_W-1:0] outData;
    logic [KW-1:0]     outKeep;
    logic              outValid, outLast, outReady = 1'b0;
    logic [79:0]       outMeta;
    logic              outMetaValid, outMetaReady = 1'b0, outMetaLast;
    logic [9:0]        outMetaKeep;
    logic [31:0]       rxPorts;
    logic [15:0]       dgmCnt, dropCnt;

    int checks = 0;
    int failures = 0;
    logic [79:0]       expMeta[$];
    logic [DATA_W+KW:0] expData[$];
    int modelDgm = 0, modelDrop = 0;
    int readyMode = 1;
    logic toggleBit = 1'b0;
    logic dataPending = 1'b0, metaPending = 1'b0;
    logic [DATA_W+KW:0] heldWord;
    logic [79:0] heldMeta;

    role_udp_echo_sf #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_DGM_WORDS(MAXW),
        .META_DEPTH(META_DEPTH), .RX_PORT_MASK(32'h0000_0001)
    ) dut (
        .piSHL_156_25Clk(clk), .piSHL_156_25Rst(rst), .piSHL_Mmio_UdpEchoCtrl(mode),
        .siNRC_Udp_Data_tdata(inData), .siNRC_Udp_Data_tkeep(inKeep),
        .siNRC_Udp_Data_tvalid(inValid), .siNRC_Udp_Data_tlast(inLast),
        .siNRC_Udp_Data_tready(inReady),
        .siNRC_Role_Udp_Meta_TDATA(inMeta), .siNRC_Role_Udp_Meta_TVALID(inMetaValid),
        .siNRC_Role_Udp_Meta_TREADY(inMetaReady), .siNRC_Role_Udp_Meta_TKEEP(inMetaKeep),
        .siNRC_Role_Udp_Meta_TLAST(inMetaLast),
        .soNRC_Udp_Data_tdata(outData), .soNRC_Udp_Data_tkeep(outKeep),
        .soNRC_Udp_Data_tvalid(outValid), .soNRC_Udp_Data_tlast(outLast),
        .soNRC_Udp_Data_tready(outReady),
        .soROLE_Nrc_Udp_Meta_TDATA(outMeta), .soROLE_Nrc_Udp_Meta_TVALID(outMetaValid),
        .soROLE_Nrc_Udp_Meta_TREADY(outMetaReady), .soROLE_Nrc_Udp_Meta_TKEEP(outMetaKeep),
        .soROLE_Nrc_Udp_Meta_TLAST(outMetaLast),
        .poROL_Nrc_Udp_Rx_ports(rxPorts), .poDgmCnt(dgmCnt), .poDropCnt(dropCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic finishRun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    endtask

    // Echoed meta built from named fields: swap pairs in mode 00, keep them otherwise.
    function automatic logic [79:0] modelMeta(input logic [79:0] m, input logic [1:0] md, input int bytes);
        logic [7:0]  dstRank, srcRank, tr;
        logic [15:0] dstPort, srcPort, tp;
        dstRank = m[7:0];   srcRank = m[15:8];
        dstPort = m[31:16]; srcPort = m[47:32];
        if (md == 2'b00) begin
            tr = dstRank; dstRank = srcRank; srcRank = tr;
            tp = dstPort; dstPort = srcPort; srcPort = tp;
        end
        return {16'h0000, 16'(bytes), srcPort, dstPort, srcRank, dstRank};
    endfunction

    // Sends one datagram from a negedge; abortAt >= 0 stops before that beat and skips the model.
    task automatic applyStimulus(input logic [79:0] meta, input logic [1:0] md, input int nWords,
                                 input logic [7:0] lastKeep, input int abortAt);
        logic [DATA_W-1:0] words[$];
        int waits, stalls, bytes;
        for (int i = 0; i < nWords; i++) words.push_back({$urandom, $urandom});
        mode        = md;
        inMeta      = meta;
        inMetaKeep  = 10'($urandom);
        inMetaLast  = 1'($urandom);
        inMetaValid = 1'b1;
        waits = 0;
        while (!inMetaReady && waits < 3000) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 3000) begin
            checkOutput("metaAcceptTimeout", 128'(waits), 128'(0));
            finishRun();
        end
        @(negedge clk);
        inMetaValid = 1'b0;
        stalls = 0;
        for (int i = 0; i < nWords; i++) begin
            if (i == abortAt) begin
                inValid = 1'b0;
                return;
            end
            inData  = words[i];
            inKeep  = (i == nWords - 1) ? lastKeep : 8'hFF;
            inLast  = (i == nWords - 1);
            inValid = 1'b1;
            waits = 0;
            while (!inReady && waits < 50) begin
                @(negedge clk);
                waits++;
            end
            stalls += waits;
            @(negedge clk);
        end
        inValid = 1'b0;
        inLast  = 1'b0;
        checkOutput("dataStall", 128'(stalls), 128'(0));
        if (md[1] || nWords > MAXW) begin
            modelDrop++;
        end else begin
            bytes = 8 * (nWords - 1) + $countones(lastKeep);
            expMeta.push_back(modelMeta(meta, md, bytes));
            for (int i = 0; i < nWords; i++)
                expData.push_back({1'(i == nWords - 1), (i == nWords - 1) ? lastKeep : 8'hFF, words[i]});
            modelDgm++;
        end
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((expMeta.size() != 0 || expData.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drain"}, 128'(expMeta.size() + expData.size()), 128'(0));
        repeat (4) @(negedge clk);
        checkOutput({tag, "_dgmCnt"}, 128'(dgmCnt), 128'(modelDgm[15:0]));
        checkOutput({tag, "_dropCnt"}, 128'(dropCnt), 128'(modelDrop[15:0]));
    endtask

    function automatic logic [79:0] randMeta();
        return {$urandom, $urandom, 16'($urandom)};
    endfunction

    // Output checker: handshakes are decided at the negedge before the edge that completes them.
    always @(negedge clk) begin
        unique case (readyMode)
            0: begin
                outReady     = $urandom_range(0, 3) != 0;
                outMetaReady = 1'($urandom_range(0, 1));
            end
            1: begin outReady = 1'b1; outMetaReady = 1'b1; end
            2: begin
                toggleBit    = ~toggleBit;
                outReady     = toggleBit;
                outMetaReady = toggleBit;
            end
            default: begin outReady = 1'b0; outMetaReady = 1'b0; end
        endcase
        if (rst) begin
            dataPending = 1'b0;
            metaPending = 1'b0;
        end else begin
            if (dataPending) begin
                checkOutput("dataHoldValid", 128'(outValid), 128'(1));
                checkOutput("dataHoldWord", 128'({outLast, outKeep, outData}), 128'(heldWord));
            end
            if (metaPending) begin
                checkOutput("metaHoldValid", 128'(outMetaValid), 128'(1));
                checkOutput("metaHoldWord", 128'(outMeta), 128'(heldMeta));
            end
            if (outValid || outMetaValid)
                checkOutput("validOverlap", 128'(outValid && outMetaValid), 128'(0));
            if (outValid && outReady) begin
                if (expData.size() == 0) checkOutput("unexpectedData", 128'(outValid), 128'(0));
                else checkOutput("dataWord", 128'({outLast, outKeep, outData}), 128'(expData.pop_front()));
            end
            if (outMetaValid && outMetaReady) begin
                if (expMeta.size() == 0) checkOutput("unexpectedMeta", 128'(outMetaValid), 128'(0));
                else checkOutput("metaWord", 128'({outMetaLast, outMetaKeep, outMeta}),
                                 128'({1'b1, 10'h3FF, expMeta.pop_front()}));
            end
            dataPending = outValid && !outReady;
            metaPending = outMetaValid && !outMetaReady;
            heldWord    = {outLast, outKeep, outData};
            heldMeta    = outMeta;
        end
    end

    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        finishRun();
    end

    initial begin
        logic [79:0] meta1, lit;
        meta1 = {16'hBEEF, 16'd999, 16'h1234, 16'h0A9E, 8'h03, 8'h01};

        repeat (2) @(negedge clk);
        checkOutput("resetDataReady", 128'(inReady), 128'(0));
        checkOutput("resetMetaReady", 128'(inMetaReady), 128'(0));
        checkOutput("resetDataValid", 128'(outValid), 128'(0));
        checkOutput("resetMetaValid", 128'(outMetaValid), 128'(0));
        checkOutput("resetDgmCnt", 128'(dgmCnt), 128'(0));
        checkOutput("resetDropCnt", 128'(dropCnt), 128'(0));
        checkOutput("rxPorts", 128'(rxPorts), 128'(32'h1));
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] mode 00 swap");
        lit = 80'h0000_0014_0A9E_1234_01_03;
        checkOutput("modelSwapPin", 128'(modelMeta(meta1, 2'b00, 20)), 128'(lit));
        applyStimulus(meta1, 2'b00, 3, 8'h0F, -1);
        waitDrain("t1");
        checkOutput("t1DgmLiteral", 128'(dgmCnt), 128'(1));

        $display("[TB] mode 01 pass-through");
        lit = 80'h0000_0014_1234_0A9E_03_01;
        checkOutput("modelPassPin", 128'(modelMeta(meta1, 2'b01, 20)), 128'(lit));
        applyStimulus(meta1, 2'b01, 3, 8'h0F, -1);
        waitDrain("t2");

        $display("[TB] oversize rollback");
        lit = 80'h0000_0010_0A9E_1234_01_03;
        checkOutput("modelLen16Pin", 128'(modelMeta(meta1, 2'b00, 16)), 128'(lit));
        applyStimulus(randMeta(), 2'b00, 6, 8'hFF, -1);
        applyStimulus(meta1, 2'b00, 2, 8'hFF, -1);
        waitDrain("t3");
        checkOutput("t3DropLiteral", 128'(dropCnt), 128'(1));
        applyStimulus(randMeta(), 2'b00, MAXW, 8'h01, -1);
        applyStimulus(randMeta(), 2'b01, MAXW + 1, 8'h7F, -1);
        applyStimulus(randMeta(), 2'b00, 1, 8'h03, -1);
        waitDrain("t3b");

        $display("[TB] toggling downstream ready");
        readyMode = 2;
        for (int i = 0; i < 5; i++)
            applyStimulus(randMeta(), 2'($urandom_range(0, 1)), $urandom_range(1, MAXW),
                          8'hFF >> $urandom_range(0, 7), -1);
        waitDrain("t4");

        $display("[TB] sink mode");
        readyMode = 1;
        for (int i = 0; i < 3; i++)
            applyStimulus(randMeta(), 2'($urandom_range(2, 3)), $urandom_range(1, 6), 8'hFF, -1);
        waitDrain("t5");

        $display("[TB] reset mid-datagram");
        readyMode = 3;
        applyStimulus(randMeta(), 2'b00, 2, 8'hFF, -1);
        applyStimulus(randMeta(), 2'b00, 2, 8'hFF, -1);
        applyStimulus(randMeta(), 2'b00, 4, 8'hFF, 2);
        checkOutput("preResetMetaValid", 128'(outMetaValid), 128'(1));
        rst = 1'b1;
        inMetaValid = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("rstDataValid", 128'(outValid), 128'(0));
        checkOutput("rstMetaValid", 128'(outMetaValid), 128'(0));
        checkOutput("rstDataReady", 128'(inReady), 128'(0));
        checkOutput("rstMetaReady", 128'(inMetaReady), 128'(0));
        checkOutput("rstDgmCnt", 128'(dgmCnt), 128'(0));
        checkOutput("rstDropCnt", 128'(dropCnt), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        expMeta.delete();
        expData.delete();
        modelDgm = 0;
        modelDrop = 0;
        readyMode = 1;
        @(negedge clk);
        applyStimulus(meta1, 2'b00, 3, 8'h0F, -1);
        waitDrain("t6");
        checkOutput("t6DgmLiteral", 128'(dgmCnt), 128'(1));

        $display("[TB] randomized traffic");
        readyMode = 0;
        for (int i = 0; i < 40; i++)
            applyStimulus(randMeta(),
                          ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)),
                          $urandom_range(1, 6), 8'hFF >> $urandom_range(0, 7), -1);
        waitDrain("rand");

        finishRun();
    end
endmodule
